// File: rtl/scan_mux_pkg.sv
// Shared types and constants for the scanning channel multiplexer.
package scan_mux_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAN  = 2'd1,
        SCAN = 2'd2
    } state_t;

    localparam logic MODE_MAN  = 1'b0;
    localparam logic MODE_SCAN = 1'b1;

    // Select width: a one-bit select is kept even for degenerate channel counts.
    function automatic int sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/scan_mux_if.sv
// Control/data bundle between the integrating level and scan_mux.
interface scan_mux_if #(
    parameter int WIDTH = 2,
    parameter int CH    = 4
);
    import scan_mux_pkg::*;
    localparam int SW = sel_w(CH);

    logic [CH*WIDTH-1:0] din;
    logic [SW-1:0]       sel;
    logic                mode;
    logic                en;
    logic [WIDTH-1:0]    dout;
    logic [SW-1:0]       ch_out;
    logic                valid;
    logic                wrap;

    modport master (output din, sel, mode, en, input dout, ch_out, valid, wrap);
    modport slave  (input din, sel, mode, en, output dout, ch_out, valid, wrap);
endinterface

// File: rtl/scan_mux_slice.sv
// Combinational CH:1 channel selector; o_legal flags an in-range select.
module mux_slice
    import scan_mux_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int CH    = 4,
    localparam int SW   = sel_w(CH)
) (
    input  logic [CH*WIDTH-1:0] i_din,
    input  logic [SW-1:0]       i_sel,
    output logic [WIDTH-1:0]    o_dout,
    output logic                o_legal
);

    always_comb begin
        o_dout  = '0;
        o_legal = 1'b0;
        for (int k = 0; k < CH; k++) begin
            if (i_sel == SW'(k)) begin
                o_dout  = i_din[k*WIDTH +: WIDTH];
                o_legal = 1'b1;
            end
        end
    end

endmodule

// File: rtl/scan_mux.sv
// Registered channel multiplexer with manual select and dwell-timed auto-scan.
module scan_mux
    import scan_mux_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int CH    = 4,
    parameter int DWELL = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    scan_mux_if.slave  bus
);

    localparam int SW = sel_w(CH);
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [SW-1:0] CH_LAST = SW'(CH - 1);
    localparam logic [DW-1:0] DW_LAST = DW'(DWELL - 1);

    state_t           r_state, w_state_nxt;
    logic [SW-1:0]    r_cur, r_ch;
    logic [DW-1:0]    r_dw;
    logic [WIDTH-1:0] r_dout;
    logic             r_valid, r_wrap;

    logic [SW-1:0]    w_cur, w_cur_nxt, w_idx;
    logic [DW-1:0]    w_dw, w_dw_nxt;
    logic             w_term, w_legal, w_sel_legal;
    logic [WIDTH-1:0] w_mux;

    always_comb begin
        w_state_nxt = r_state;
        if (bus.en)
            w_state_nxt = (bus.mode == MODE_SCAN) ? SCAN : MAN;
    end

    // Entering scan from MAN starts at the manual channel; from IDLE at 0.
    always_comb begin
        w_cur = r_cur;
        w_dw  = r_dw;
        if (r_state != SCAN) begin
            w_dw  = '0;
            w_cur = (r_state == MAN && w_sel_legal) ? bus.sel : '0;
        end
        w_term    = (w_dw == DW_LAST);
        w_dw_nxt  = w_term ? '0 : w_dw + 1'b1;
        w_cur_nxt = w_cur;
        if (w_term)
            w_cur_nxt = (w_cur == CH_LAST) ? '0 : w_cur + 1'b1;
        w_idx = (bus.mode == MODE_SCAN) ? w_cur : bus.sel;
    end

    assign w_sel_legal = ({1'b0, bus.sel} <= {1'b0, CH_LAST});

    mux_slice #(.WIDTH(WIDTH), .CH(CH)) u_mux (
        .i_din   (bus.din),
        .i_sel   (w_idx),
        .o_dout  (w_mux),
        .o_legal (w_legal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cur   <= '0;
            r_dw    <= '0;
            r_dout  <= '0;
            r_ch    <= '0;
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wrap  <= 1'b0;
            if (bus.en) begin
                if (bus.mode == MODE_SCAN) begin
                    r_dout  <= w_mux;
                    r_ch    <= w_cur;
                    r_valid <= 1'b1;
                    r_cur   <= w_cur_nxt;
                    r_dw    <= w_dw_nxt;
                    // Channel 0 at count 0 while already scanning only follows a wrap.
                    r_wrap  <= (r_state == SCAN) && (r_cur == '0) && (r_dw == '0);
                end else begin
                    r_dw <= '0;
                    if (w_legal) begin
                        r_dout  <= w_mux;
                        r_ch    <= bus.sel;
                        r_valid <= 1'b1;
                    end else begin
                        r_dout  <= '0;
                        r_valid <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.dout   = r_dout;
    assign bus.ch_out = r_ch;
    assign bus.valid  = r_valid;
    assign bus.wrap   = r_wrap;

endmodule

// File: tb/tb_scan_mux.sv
// Directed bench for scan_mux: vector table on a 4-channel instance plus corner sequences.
module tb_scan_mux;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    scan_mux_if #(.WIDTH(2), .CH(4)) ifa ();
    scan_mux_if #(.WIDTH(2), .CH(3)) ifb ();

    scan_mux #(.WIDTH(2), .CH(4), .DWELL(3)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    scan_mux #(.WIDTH(2), .CH(3), .DWELL(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    typedef struct {
        logic       en;
        logic       mode;
        logic [1:0] sel;
        logic [7:0] din;
        logic [1:0] dout;
        logic [1:0] ch;
        logic       valid;
        logic       wrap;
    } vec_t;

    vec_t vt [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drive_a(input logic en, input logic mode, input logic [1:0] sel, input logic [7:0] din);
        ifa.en   = en;
        ifa.mode = mode;
        ifa.sel  = sel;
        ifa.din  = din;
    endtask

    task automatic chk_a(input string nm, input logic [1:0] d, input logic [1:0] c,
                         input logic v, input logic w);
        chk({nm, ".dout"},  32'(ifa.dout),   32'(d));
        chk({nm, ".ch"},    32'(ifa.ch_out), 32'(c));
        chk({nm, ".valid"}, 32'(ifa.valid),  32'(v));
        chk({nm, ".wrap"},  32'(ifa.wrap),   32'(w));
    endtask

    initial begin
        // din E4: slice k = k.  din 1B: slice k = 3-k.
        vt[0]  = '{1'b1, 1'b0, 2'd2, 8'hE4, 2'd2, 2'd2, 1'b1, 1'b0};
        vt[1]  = '{1'b1, 1'b0, 2'd1, 8'hE4, 2'd1, 2'd1, 1'b1, 1'b0};
        vt[2]  = '{1'b1, 1'b0, 2'd3, 8'h1B, 2'd0, 2'd3, 1'b1, 1'b0};
        vt[3]  = '{1'b1, 1'b0, 2'd2, 8'h1B, 2'd1, 2'd2, 1'b1, 1'b0};
        vt[4]  = '{1'b1, 1'b1, 2'd2, 8'hE4, 2'd2, 2'd2, 1'b1, 1'b0};
        vt[5]  = '{1'b1, 1'b1, 2'd2, 8'hE4, 2'd2, 2'd2, 1'b1, 1'b0};
        vt[6]  = '{1'b1, 1'b1, 2'd0, 8'h1B, 2'd1, 2'd2, 1'b1, 1'b0};
        vt[7]  = '{1'b1, 1'b1, 2'd0, 8'hE4, 2'd3, 2'd3, 1'b1, 1'b0};
        vt[8]  = '{1'b0, 1'b1, 2'd0, 8'h1B, 2'd3, 2'd3, 1'b1, 1'b0};
        vt[9]  = '{1'b0, 1'b0, 2'd0, 8'hE4, 2'd3, 2'd3, 1'b1, 1'b0};
        vt[10] = '{1'b1, 1'b1, 2'd0, 8'hE4, 2'd3, 2'd3, 1'b1, 1'b0};
        vt[11] = '{1'b1, 1'b1, 2'd0, 8'h1B, 2'd0, 2'd3, 1'b1, 1'b0};
        vt[12] = '{1'b1, 1'b1, 2'd0, 8'hE4, 2'd0, 2'd0, 1'b1, 1'b1};
        vt[13] = '{1'b1, 1'b1, 2'd0, 8'h1B, 2'd3, 2'd0, 1'b1, 1'b0};
        vt[14] = '{1'b1, 1'b0, 2'd1, 8'hE4, 2'd1, 2'd1, 1'b1, 1'b0};
        vt[15] = '{1'b1, 1'b1, 2'd1, 8'h1B, 2'd2, 2'd1, 1'b1, 1'b0};

        drive_a(1'b0, 1'b0, 2'd0, 8'h00);
        ifb.en = 1'b0; ifb.mode = 1'b0; ifb.sel = 2'd0; ifb.din = 6'h00;
        do_reset();

        chk_a("reset_a", 2'd0, 2'd0, 1'b0, 1'b0);
        chk("reset_b.valid", 32'(ifb.valid), 32'd0);

        for (int i = 0; i < 16; i++) begin
            drive_a(vt[i].en, vt[i].mode, vt[i].sel, vt[i].din);
            tick();
            chk_a($sformatf("vec%0d", i), vt[i].dout, vt[i].ch, vt[i].valid, vt[i].wrap);
        end

        // Full scan cycle from reset: three samples per channel, one wrap on return to 0.
        drive_a(1'b0, 1'b1, 2'd0, 8'hE4);
        do_reset();
        ifa.en = 1'b1;
        for (int i = 0; i < 13; i++) begin
            tick();
            chk($sformatf("scan%0d.ch", i),   32'(ifa.ch_out), 32'((i / 3) % 4));
            chk($sformatf("scan%0d.dout", i), 32'(ifa.dout),   32'((i / 3) % 4));
            chk($sformatf("scan%0d.wrap", i), 32'(ifa.wrap),   32'(i == 12));
        end
        ifa.en = 1'b0;
        tick();
        chk("wrap_off_when_frozen", 32'(ifa.wrap), 32'd0);

        // Freeze mid-dwell on channel 1 (one sample already taken there).
        drive_a(1'b0, 1'b1, 2'd0, 8'hE4);
        do_reset();
        ifa.en = 1'b1;
        repeat (4) tick();
        drive_a(1'b0, 1'b0, 2'd3, 8'h1B);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_a($sformatf("freeze%0d", i), 2'd1, 2'd1, 1'b1, 1'b0);
        end
        drive_a(1'b1, 1'b1, 2'd0, 8'hE4);
        tick(); chk("resume0.ch", 32'(ifa.ch_out), 32'd1);
        tick(); chk("resume1.ch", 32'(ifa.ch_out), 32'd1);
        tick(); chk("resume2.ch", 32'(ifa.ch_out), 32'd2);

        // Asynchronous reset while sitting on channel 3.
        drive_a(1'b0, 1'b1, 2'd0, 8'hE4);
        do_reset();
        ifa.en = 1'b1;
        repeat (10) tick();
        chk("pre_rst.ch", 32'(ifa.ch_out), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk_a("async_rst", 2'd0, 2'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick(); chk_a("restart0", 2'd0, 2'd0, 1'b1, 1'b0);
        repeat (3) tick();
        chk("restart3.ch", 32'(ifa.ch_out), 32'd1);

        // Three-channel instance: illegal select and entry from an illegal select.
        ifa.en = 1'b0;
        ifb.din = 6'b10_11_01;
        ifb.en = 1'b1; ifb.mode = 1'b0; ifb.sel = 2'd1;
        tick();
        chk("b_sel1.dout", 32'(ifb.dout), 32'd3);
        chk("b_sel1.valid", 32'(ifb.valid), 32'd1);
        ifb.sel = 2'd3;
        tick();
        chk("b_ill.dout", 32'(ifb.dout), 32'd0);
        chk("b_ill.valid", 32'(ifb.valid), 32'd0);
        chk("b_ill.ch", 32'(ifb.ch_out), 32'd1);
        ifb.sel = 2'd1;
        tick();
        chk("b_back.dout", 32'(ifb.dout), 32'd3);
        chk("b_back.valid", 32'(ifb.valid), 32'd1);
        ifb.sel = 2'd3;
        tick();
        ifb.mode = 1'b1;
        tick();
        chk("b_entry.ch", 32'(ifb.ch_out), 32'd0);
        chk("b_entry.dout", 32'(ifb.dout), 32'd1);
        chk("b_entry.valid", 32'(ifb.valid), 32'd1);
        for (int i = 1; i < 7; i++) begin
            tick();
            chk($sformatf("b_scan%0d.ch", i),   32'(ifb.ch_out), 32'((i / 2) % 3));
            chk($sformatf("b_scan%0d.wrap", i), 32'(ifb.wrap),   32'(i == 6));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
